// File: rtl/fifo_sched_pkg.sv
// Shared types and defaults for the fifo_fsm front-end scheduler.
// Holds the scheduler state encoding and the default word width.
package fifo_sched_pkg;

   localparam int DATA_W_DEF = 8;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } sched_state_t;

endpackage

// File: rtl/fifo_port_sched_rr_arb2.sv
// Two-request round-robin arbiter with a one-hot grant.
// The requester not granted most recently wins a tie; p0 wins the first tie after reset.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);

   logic r_last_p1;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req == 2'b11) gnt = r_last_p1 ? 2'b01 : 2'b10;
         else              gnt = req;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)    r_last_p1 <= 1'b1;
      else if (|gnt) r_last_p1 <= gnt[1];
   end

endmodule

// File: rtl/fifo_port_sched.sv
// Front-end scheduler for fifo_fsm: arbitrates two producers onto the write port,
// gates the consumer read port, tracks occupancy itself and can drain the FIFO.
module fifo_port_sched
   import fifo_sched_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic [DATA_W-1:0] p0_data,
   output logic              p0_ack,
   input  logic              p1_req,
   input  logic [DATA_W-1:0] p1_data,
   output logic              p1_ack,
   input  logic              c_req,
   output logic              c_ack,
   output logic              c_valid,
   output logic [DATA_W-1:0] c_data,
   input  logic              flush_req,
   output logic              flush_done,
   output logic              fifo_wr_en,
   output logic [DATA_W-1:0] fifo_din,
   output logic              fifo_rd_en,
   input  logic [DATA_W-1:0] fifo_dout,
   input  logic              fifo_full,
   input  logic              fifo_empty,
   output logic [CNT_W-1:0]  level,
   output logic              err
);

   localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(DEPTH);

   sched_state_t     r_state;
   logic [CNT_W-1:0] r_level;
   logic             r_c_valid;
   logic             r_flush_done;
   logic             r_err;

   logic       w_run;
   logic       w_wr_ok;
   logic       w_rd_ok;
   logic [1:0] w_gnt;
   logic       w_wr;
   logic       w_rd;

   // Bounds use only our own count, so full/empty timing in the FIFO never matters.
   assign w_run   = (r_state == ST_RUN);
   assign w_wr_ok = reset & w_run & (r_level < LP_DEPTH);
   assign w_rd_ok = reset & (r_level != '0);

   rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   ({p1_req, p0_req}),
      .en    (w_wr_ok),
      .gnt   (w_gnt)
   );

   assign p0_ack     = w_gnt[0];
   assign p1_ack     = w_gnt[1];
   assign w_wr       = |w_gnt;
   assign fifo_wr_en = w_wr;
   assign fifo_din   = w_gnt[1] ? p1_data : p0_data;

   // A flush reads on its own; the consumer sees no grant until we are back in RUN.
   assign c_ack      = w_run & c_req & w_rd_ok;
   assign w_rd       = w_run ? c_ack : w_rd_ok;
   assign fifo_rd_en = w_rd;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_RUN;
         r_level      <= '0;
         r_c_valid    <= 1'b0;
         r_flush_done <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         unique case ({w_wr, w_rd})
            2'b10:   r_level <= r_level + CNT_W'(1);
            2'b01:   r_level <= r_level - CNT_W'(1);
            default: r_level <= r_level;
         endcase

         r_flush_done <= 1'b0;
         unique case (r_state)
            ST_RUN: if (flush_req) r_state <= ST_FLUSH;
            ST_FLUSH: begin
               if (r_level == '0) begin
                  r_state      <= ST_RUN;
                  r_flush_done <= 1'b1;
               end
            end
            default: r_state <= ST_RUN;
         endcase

         r_c_valid <= c_ack;
         r_err     <= r_err | (w_wr & fifo_full) | (w_rd & fifo_empty);
      end
   end

   assign c_valid    = r_c_valid;
   assign c_data     = r_c_valid ? fifo_dout : '0;
   assign flush_done = r_flush_done;
   assign level      = r_level;
   assign err        = r_err;

endmodule

// File: tb/tb_fifo_port_sched.sv
// Directed bench for fifo_port_sched with a behavioural FIFO behind it.
// Expected writes and reads go into queues; a monitor compares them as the DUT presents them.
module tb_fifo_port_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic       p0_req, p1_req, c_req, flush_req;
   logic [7:0] p0_data, p1_data;
   logic       p0_ack, p1_ack, c_ack, c_valid, flush_done;
   logic [7:0] c_data, fifo_din, fifo_dout;
   logic       fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty;
   logic [3:0] level;
   logic       err;
   logic       force_full;

   typedef struct packed {
      logic       port;
      logic [7:0] data;
   } wr_t;

   wr_t        exp_wr[$];
   logic [7:0] exp_rd[$];
   logic [7:0] fifo_q[$];
   int         q_cnt;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   fifo_port_sched dut (
      .clk        (clk),
      .reset      (reset),
      .p0_req     (p0_req),
      .p0_data    (p0_data),
      .p0_ack     (p0_ack),
      .p1_req     (p1_req),
      .p1_data    (p1_data),
      .p1_ack     (p1_ack),
      .c_req      (c_req),
      .c_ack      (c_ack),
      .c_valid    (c_valid),
      .c_data     (c_data),
      .flush_req  (flush_req),
      .flush_done (flush_done),
      .fifo_wr_en (fifo_wr_en),
      .fifo_din   (fifo_din),
      .fifo_rd_en (fifo_rd_en),
      .fifo_dout  (fifo_dout),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty),
      .level      (level),
      .err        (err)
   );

   // Behavioural FIFO: registered read data, cleared by the same reset.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         fifo_q.delete();
         fifo_dout <= 8'h00;
         q_cnt = 0;
      end else begin
         if (fifo_rd_en && fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
         if (fifo_wr_en) fifo_q.push_back(fifo_din);
         q_cnt = fifo_q.size();
      end
   end

   assign fifo_full  = (q_cnt == 8) | force_full;
   assign fifo_empty = (q_cnt == 0);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // Monitor: pops the scoreboards whenever a write or a read-data beat is presented.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (fifo_wr_en) begin
            if (exp_wr.size() == 0) check("wr_unexpected", {24'h0, fifo_din}, 32'hFFFF_FFFF);
            else begin
               wr_t e;
               e = exp_wr.pop_front();
               check("wr_port", {30'h0, p1_ack, p0_ack}, e.port ? 32'd2 : 32'd1);
               check("wr_data", {24'h0, fifo_din}, {24'h0, e.data});
            end
         end
         if (c_valid) begin
            if (exp_rd.size() == 0) check("rd_unexpected", {24'h0, c_data}, 32'hFFFF_FFFF);
            else check("rd_data", {24'h0, c_data}, {24'h0, exp_rd.pop_front()});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n_ack, n_rd, n_p0, n_cv;
      bit  done;

      reset = 1'b0; p0_req = 0; p1_req = 0; c_req = 0; flush_req = 0;
      p0_data = 8'h00; p1_data = 8'h00; force_full = 0;
      repeat (2) cyc();
      mid();
      check("rst_level", 32'(level), 0);
      check("rst_grants", {28'h0, p0_ack, p1_ack, fifo_wr_en, fifo_rd_en}, 0);
      check("rst_flags", {29'h0, c_valid, flush_done, err}, 0);
      cyc();
      reset = 1'b1;
      cyc();

      // Single p0 write: zero-latency ack
      exp_wr.push_back('{1'b0, 8'hA5});
      p0_req = 1; p0_data = 8'hA5;
      mid();
      check("a5_ack", {30'h0, p0_ack, fifo_wr_en}, 32'd3);
      cyc();
      p0_req = 0;
      check("a5_level", 32'(level), 1);

      // Fresh reset so the round-robin pointer starts on p0 again
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      cyc();

      // Both producers request: alternate p0,p1,... until level reaches 8
      for (int i = 0; i < 8; i++) exp_wr.push_back('{i[0], (i[0] ? 8'h61 : 8'h50)});
      p0_req = 1; p0_data = 8'h50; p1_req = 1; p1_data = 8'h61;
      repeat (8) cyc();
      mid();
      check("full_level", 32'(level), 8);
      check("full_stall", {29'h0, p0_ack, p1_ack, fifo_wr_en}, 0);

      // Read at level 8 with producers still requesting: write blocked
      cyc();
      exp_rd.push_back(8'h50);
      c_req = 1;
      mid();
      check("full_rw_cack", 32'(c_ack), 1);
      check("full_rw_wr", 32'(fifo_wr_en), 0);
      cyc();
      c_req = 0; p0_req = 0; p1_req = 0;
      check("full_rw_level", 32'(level), 7);

      // Drain the rest; c_ack must drop once level is 0
      for (int i = 0; i < 7; i++) exp_rd.push_back(i[0] ? 8'h50 : 8'h61);
      c_req = 1;
      repeat (7) cyc();
      mid();
      check("drain_level", 32'(level), 0);
      check("empty_cack", 32'(c_ack), 0);
      cyc();

      // Write and read together at level 0: read blocked
      exp_wr.push_back('{1'b1, 8'h77});
      p1_req = 1; p1_data = 8'h77;
      mid();
      check("empty_rw_cack", 32'(c_ack), 0);
      check("empty_rw_rd", 32'(fifo_rd_en), 0);
      cyc();
      p1_req = 0; c_req = 0;
      check("empty_rw_level", 32'(level), 1);
      exp_rd.push_back(8'h77);
      c_req = 1;
      cyc();
      c_req = 0;
      cyc();

      // Three writes then a held read: three grants, data in order
      exp_wr.push_back('{1'b0, 8'h11});
      exp_wr.push_back('{1'b0, 8'h22});
      exp_wr.push_back('{1'b0, 8'h33});
      p0_req = 1; p0_data = 8'h11;
      cyc();
      p0_data = 8'h22;
      cyc();
      p0_data = 8'h33;
      cyc();
      p0_req = 0;
      exp_rd.push_back(8'h11);
      exp_rd.push_back(8'h22);
      exp_rd.push_back(8'h33);
      c_req = 1;
      n_ack = 0;
      repeat (5) begin
         mid();
         if (c_ack) n_ack++;
         cyc();
      end
      c_req = 0;
      check("three_cacks", 32'(n_ack), 3);
      check("three_level", 32'(level), 0);

      // Flush from level 5 with p0 waiting
      for (int i = 0; i < 5; i++) begin
         exp_wr.push_back('{1'b1, 8'h81 + 8'(i)});
         p1_req = 1; p1_data = 8'h81 + 8'(i);
         cyc();
      end
      p1_req = 0;
      mid();
      check("flush_pre_level", 32'(level), 5);
      cyc();
      flush_req = 1;
      cyc();
      flush_req = 0;
      exp_wr.push_back('{1'b0, 8'h99});
      p0_req = 1; p0_data = 8'h99;
      n_rd = 0; n_p0 = 0; n_cv = 0; done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         mid();
         if (flush_done) done = 1;
         else begin
            if (fifo_rd_en) n_rd++;
            if (p0_ack) n_p0++;
            if (c_valid) n_cv++;
            cyc();
         end
      end
      check("flush_done_seen", 32'(done), 1);
      check("flush_reads", 32'(n_rd), 5);
      check("flush_no_p0", 32'(n_p0), 0);
      check("flush_no_cvalid", 32'(n_cv), 0);
      check("flush_p0_after", 32'(p0_ack), 1);
      cyc();
      p0_req = 0;
      mid();
      check("flush_done_pulse", 32'(flush_done), 0);
      check("flush_post_level", 32'(level), 1);

      // Flush at level 0: one FLUSH cycle, then the pulse
      cyc();
      exp_rd.push_back(8'h99);
      c_req = 1;
      cyc();
      c_req = 0;
      cyc();
      flush_req = 1;
      mid();
      check("f0_done_c0", 32'(flush_done), 0);
      cyc();
      flush_req = 0;
      mid();
      check("f0_done_c1", {30'h0, flush_done, fifo_rd_en}, 0);
      cyc();
      mid();
      check("f0_done_c2", 32'(flush_done), 1);
      cyc();
      mid();
      check("f0_done_c3", 32'(flush_done), 0);

      // Reset in the middle of a flush
      cyc();
      for (int i = 0; i < 3; i++) begin
         exp_wr.push_back('{1'b1, 8'hC0 + 8'(i)});
         p1_req = 1; p1_data = 8'hC0 + 8'(i);
         cyc();
      end
      p1_req = 0;
      flush_req = 1;
      cyc();
      flush_req = 0;
      mid();
      check("mid_flush_rd", 32'(fifo_rd_en), 1);
      reset = 1'b0;
      #1;
      check("mid_rst_level", 32'(level), 0);
      check("mid_rst_rd", 32'(fifo_rd_en), 0);
      cyc();
      reset = 1'b1;
      n_ack = 0;
      repeat (3) begin
         mid();
         if (flush_done) n_ack++;
         cyc();
      end
      check("mid_rst_no_done", 32'(n_ack), 0);
      check("mid_rst_level2", 32'(level), 0);

      // Write while the FIFO claims to be full: sticky err
      exp_wr.push_back('{1'b0, 8'h42});
      force_full = 1; p0_req = 1; p0_data = 8'h42;
      cyc();
      p0_req = 0; force_full = 0;
      mid();
      check("err_set", 32'(err), 1);
      repeat (3) cyc();
      check("err_sticky", 32'(err), 1);
      reset = 1'b0;
      #1;
      check("err_cleared", 32'(err), 0);
      cyc();
      reset = 1'b1;
      cyc();

      check("wr_queue_drained", 32'(exp_wr.size()), 0);
      check("rd_queue_drained", 32'(exp_rd.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_port_sched.md
# fifo_port_sched

Front-end scheduler for the `fifo_fsm` FIFO.
- Shares the single FIFO write port between two producers using round-robin arbitration, and gates the read port for one consumer.
- Keeps its own occupancy count, so overflow and underflow cannot happen regardless of when `full`/`empty` update.
- Provides a flush sequence that drains the FIFO to empty.
- Sits between the producer/consumer logic and `fifo_fsm`, and drives all FIFO enables.

## Interface
- `DATA_W`, 8: word width; must match the FIFO.
- `DEPTH`, 8: FIFO capacity in words; must match the FIFO.
- `CNT_W`, `$clog2(DEPTH+1)`: occupancy counter width (derived).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `p0_req` in 1 / `p0_data` in DATA_W / `p0_ack` out 1: producer 0 write handshake.
- `p1_req` in 1 / `p1_data` in DATA_W / `p1_ack` out 1: producer 1 write handshake.
- `c_req` in 1 / `c_ack` out 1: consumer read request and grant.
- `c_valid` out 1 / `c_data` out DATA_W: consumer read data.
- `flush_req` in 1 / `flush_done` out 1: drain request and completion pulse.
- `fifo_wr_en` out 1 / `fifo_din` out DATA_W: to the FIFO write port.
- `fifo_rd_en` out 1 / `fifo_dout` in DATA_W: FIFO read port.
- `fifo_full` in 1 / `fifo_empty` in 1: FIFO status, used only for checking.
- `level` out CNT_W: scheduler occupancy count.
- `err` out 1: sticky protocol-mismatch flag.

## Operation
- State machine, 2 states:
  - RUN: normal operation.
  - FLUSH: entered on the next edge when `flush_req`=1 in RUN.
  - FLUSH exits to RUN on the edge where `level`=0. `flush_done` is a registered 1-cycle pulse in the first cycle back in RUN.
  - `flush_req` is ignored while in FLUSH.
- Write grant (combinational), RUN only, when `level` < `DEPTH`:
  - Exactly one requesting producer gets `pX_ack`=1, `fifo_wr_en`=1, `fifo_din`=`pX_data`.
  - If both request, the producer not granted most recently wins.
  - The round-robin pointer updates on each grant. After reset, p0 has priority.
- Producer handshake:
  - A producer holds `req` and `data` until it sees `ack` high.
  - The transfer completes in the `ack` cycle.
  - The producer may drop `req` or present new data from the next cycle.
- Read grant (combinational):
  - In RUN: `c_ack`=`fifo_rd_en`=`c_req` & (`level`>0).
  - In FLUSH: `fifo_rd_en`=(`level`>0) and `c_ack`=0.
- Read data:
  - `c_valid` is a registered copy of (`c_ack`) and rises 1 cycle after the grant.
  - `c_data`=`fifo_dout` (passthrough) while `c_valid`=1.
  - Flush reads never raise `c_valid`.
- `level` update: +1 on write, −1 on read, unchanged when both occur in the same cycle.
- Conservative bounds:
  - No write when `level`=`DEPTH`, even if a read happens in the same cycle.
  - No read when `level`=0, even if a write happens in the same cycle.
- `err` is set (sticky until reset) when `fifo_wr_en`&`fifo_full` or `fifo_rd_en`&`fifo_empty`.
- While `reset` is asserted, all combinational grants are forced to 0.

## Timing
- Reset values:
  - State: RUN; `level`=0; round-robin pointer favours p0.
  - Outputs: `c_valid`=0, `flush_done`=0, `err`=0, all acks and enables 0.
- Write latency: 0 cycles, req→ack. Read latency: data valid 1 cycle after `c_ack`.
- Maximum throughput: one write and one read per cycle.
- Reset asserted mid-FLUSH:
  - State returns to RUN with `level`=0 and no `flush_done` pulse.
  - The FIFO is reset by the same signal.
- `flush_req` with `level`=0:
  - Enters FLUSH for 1 cycle, returns to RUN, then pulses `flush_done`.
- In the cycle the FSM moves RUN→FLUSH, grants still follow RUN rules.

## Structure
- Package `fifo_sched_pkg`: state enum (RUN, FLUSH) and the `DATA_W` default.
- Sub-module `rr_arb2`: 2-request round-robin arbiter.
  - Inputs: `req[1:0]`, `en`. Output: one-hot `gnt[1:0]`.
  - Owns the pointer register, which updates when any grant is given.
- Top level: FSM, `level` counter, read gating, `c_valid`/`flush_done` registers, `err`.

## Test plan
- Reset, then p0 writes 0xA5 alone → `p0_ack`/`fifo_wr_en` high in the same cycle, `fifo_din`=0xA5, `level` 0→1.
- p0 and p1 request continuously → acks alternate p0,p1,p0,…; stalls once `level`=8 with `p0_ack`=`p1_ack`=0.
- Fill to 8, then read and write in the same cycle → write blocked, `level`=7. From `level`=0, write and read together → read blocked, `level`=1.
- Write 0x11,0x22,0x33, then hold `c_req` → three `c_ack` pulses, `c_valid` on the next cycles with `c_data` 0x11,0x22,0x33; `c_ack`=0 at `level`=0.
- `level`=5, pulse `flush_req` with `p0_req` high → 5 `fifo_rd_en` cycles, no `p0_ack`, `c_valid`=0, then `flush_done` 1-cycle pulse; p0 is granted afterwards.
- Hold `fifo_full`=1 externally during a write → `err`=1 and stays set until `reset` is asserted low.
